input_debouncer: RTL and testbench

//   Upstream conditioning stage for a single-bit pad input (ui_in[0]) before it

---
 rtl/input_debouncer.sv | 119 +++++++++++
 tb/tb_input_debouncer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus a two-state qualify FSM; dout only flips after STABLE_CYCLES of agreement.
// Optional on/off latch output enabled by defining INPUT_DEBOUNCER_TOGGLE_EN.
module input_debouncer #(
   parameter int   STABLE_CYCLES = 50000,
   parameter int   CNT_W         = 16,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
   ,
   output logic toggle
`endif
);

   typedef enum logic {
      STABLE = 1'b0,
      SETTLE = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state, state_nxt;
   logic             sync1, sync2;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dout_nxt, rise_nxt, fall_nxt;

   generate
      if (STABLE_CYCLES < 1 || (2 ** CNT_W) <= STABLE_CYCLES) begin : g_param_check
         $error("input_debouncer: need STABLE_CYCLES >= 1 and 2**CNT_W > STABLE_CYCLES");
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= RESET_LEVEL;
         sync2 <= RESET_LEVEL;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= STABLE;
         cnt        <= '0;
         dout       <= RESET_LEVEL;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         dout       <= dout_nxt;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
      end
   end

   // A commit registers the new level and its strobe on the same edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dout_nxt  = dout;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         STABLE: begin
            cnt_nxt = '0;
            if (sync2 != dout) begin
               if (STABLE_CYCLES == 1) begin
                  dout_nxt = sync2;
                  rise_nxt = sync2;
                  fall_nxt = ~sync2;
               end else begin
                  cnt_nxt   = CNT_W'(1);
                  state_nxt = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (sync2 == dout) begin
               cnt_nxt   = '0;
               state_nxt = STABLE;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = STABLE;
               dout_nxt  = sync2;
               rise_nxt  = sync2;
               fall_nxt  = ~sync2;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy = (state == SETTLE);

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle <= 1'b0;
      end else if (rise_pulse) begin
         toggle <= ~toggle;
      end
   end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_CYCLES=4, CNT_W=3, RESET_LEVEL=0.
// Define INPUT_DEBOUNCER_TOGGLE_EN to also exercise the toggle latch.
module tb_input_debouncer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic dout, rise_pulse, fall_pulse, busy;
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
   logic toggle;
`endif

   int checks = 0;
   int errors = 0;

   input_debouncer #(
      .STABLE_CYCLES(4),
      .CNT_W        (3),
      .RESET_LEVEL  (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .dout      (dout),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .busy      (busy)
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
      ,
      .toggle    (toggle)
`endif
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge; inputs set here are sampled at the following edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         din = ~din;
         tick(1);
         checks++;
         if ({dout, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold cyc%0d: dout/rise/fall/busy=%b expected 0000", i, {dout, rise_pulse, fall_pulse, busy});
         end
      end
      din = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         checks++;
         if ({dout, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release cyc%0d: dout/rise/fall/busy=%b expected 0000", i, {dout, rise_pulse, fall_pulse, busy});
         end
      end
   endtask

   // din steps 0->1 before edge k; observations are taken after edges k..k+6.
   task automatic test_rise();
      logic [3:0] exp_v [7];
      // {dout, rise, fall, busy} after edge k+i
      exp_v = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
      din = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         checks++;
         if ({dout, rise_pulse, fall_pulse, busy} !== exp_v[i]) begin
            errors++;
            $display("FAIL rise k+%0d: dout/rise/fall/busy=%b expected %b", i, {dout, rise_pulse, fall_pulse, busy}, exp_v[i]);
         end
      end
   endtask

   task automatic test_fall();
      logic [3:0] exp_v [7];
      int         rise_seen;
      exp_v = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000};
      rise_seen = 0;
      din = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         if (rise_pulse === 1'b1) rise_seen++;
         checks++;
         if ({dout, rise_pulse, fall_pulse, busy} !== exp_v[i]) begin
            errors++;
            $display("FAIL fall k+%0d: dout/rise/fall/busy=%b expected %b", i, {dout, rise_pulse, fall_pulse, busy}, exp_v[i]);
         end
      end
      checks++;
      if (rise_seen !== 0) begin
         errors++;
         $display("FAIL fall_no_rise: rise_pulse seen %0d times expected 0", rise_seen);
      end
   endtask

   // din high for 3 sample edges: the drop reaches sync2 exactly when cnt == STABLE_CYCLES-1, so it aborts.
   task automatic test_bounce();
      logic [3:0] exp_v [9];
      exp_v = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      din = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i == 3) din = 1'b0;
         tick(1);
         checks++;
         if ({dout, rise_pulse, fall_pulse, busy} !== exp_v[i]) begin
            errors++;
            $display("FAIL bounce k+%0d: dout/rise/fall/busy=%b expected %b", i, {dout, rise_pulse, fall_pulse, busy}, exp_v[i]);
         end
      end
   endtask

   task automatic test_reset_mid_settle();
      din = 1'b1;
      tick(4);  // after edge k+3: SETTLE with cnt == 2
      checks++;
      if (busy !== 1'b1 || dout !== 1'b0) begin
         errors++;
         $display("FAIL mid_settle_pre: busy=%b dout=%b expected busy=1 dout=0", busy, dout);
      end
      rst = 1'b1;
      din = 1'b0;
      #1;
      checks++;
      if ({dout, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_settle_async: dout/rise/fall/busy=%b expected 0000", {dout, rise_pulse, fall_pulse, busy});
      end
      tick(2);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         checks++;
         if ({dout, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_settle_after cyc%0d: dout/rise/fall/busy=%b expected 0000", i, {dout, rise_pulse, fall_pulse, busy});
         end
      end
   endtask

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
   task automatic test_toggle();
      logic exp_t [3];
      exp_t = '{1'b1, 1'b0, 1'b1};
      checks++;
      if (toggle !== 1'b0) begin
         errors++;
         $display("FAIL toggle_init: toggle=%b expected 0", toggle);
      end
      for (int p = 0; p < 3; p++) begin
         din = 1'b1;
         tick(8);
         din = 1'b0;
         tick(8);
         checks++;
         if (toggle !== exp_t[p]) begin
            errors++;
            $display("FAIL toggle_press%0d: toggle=%b expected %b", p, toggle, exp_t[p]);
         end
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      din = 1'b0;
      #1;
      test_reset();
      test_rise();
      test_fall();
      test_bounce();
      test_reset_mid_settle();
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
      test_toggle();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within 100000 time units");
      $fatal(1);
   end

endmodule
